// File: rtl/cmpl_div.sv
// -----------------------------------------------------------------------------
// cmpl_div -- iterative fixed-point complex divider
//
// Computes q = a / b = (a * conj(b)) / |b|^2 with the quotient scaled by
// 2^FRAC_BITS. One operand pair is in flight at a time. The two numerator
// components share the denominator and are divided in parallel by a
// restoring divider that retires one quotient bit per cycle.
//
// Latency: operands accepted at edge k give out_valid after edge
// k + OUT_WIDTH + 2. Throughput: one result every OUT_WIDTH + 3 cycles.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   in_valid     operand pair present
//   in_ready     divider idle, operands accepted when in_valid & in_ready
//   dataa_real   signed numerator, real part
//   dataa_imag   signed numerator, imaginary part
//   datab_real   signed denominator, real part
//   datab_imag   signed denominator, imaginary part
//   out_valid    one-cycle pulse, result fields valid
//   result_real  signed quotient, real part (held until next out_valid)
//   result_imag  signed quotient, imaginary part (held until next out_valid)
//   ovf          saturation occurred on either component
//   div_zero     denominator was 0 + 0j
// -----------------------------------------------------------------------------
module cmpl_div #(
    parameter int DATA_WIDTH = 18,
    parameter int OUT_WIDTH  = 18,
    parameter int FRAC_BITS  = 14
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] dataa_real,
    input  logic signed [DATA_WIDTH-1:0] dataa_imag,
    input  logic signed [DATA_WIDTH-1:0] datab_real,
    input  logic signed [DATA_WIDTH-1:0] datab_imag,
    output logic                         out_valid,
    output logic signed [OUT_WIDTH-1:0]  result_real,
    output logic signed [OUT_WIDTH-1:0]  result_imag,
    output logic                         ovf,
    output logic                         div_zero
);

    // Product width, and numerator / denominator width (one guard bit).
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int NW    = PW + 1;
    // Largest left shift applied to a NW-bit value anywhere in the datapath.
    localparam int SH    = (FRAC_BITS > OUT_WIDTH - 1) ? FRAC_BITS : OUT_WIDTH - 1;
    // Remainder / shifted-divisor width.
    localparam int CW    = NW + SH;
    localparam int CNT_W = $clog2(OUT_WIDTH);

    localparam logic [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_CHECK,
        S_DIV,
        S_DONE
    } state_t;

    state_t state;

    // Registered operands.
    logic signed [DATA_WIDTH-1:0] a_re, a_im, b_re, b_im;

    // Division datapath.
    logic [CW-1:0]          rem_re, rem_im;   // |N| * 2^F, reduced as bits retire
    logic [CW-1:0]          den;              // D, zero-extended
    logic [CW-1:0]          dshift;           // D << current bit position
    logic [OUT_WIDTH-2:0]   quo_re, quo_im;
    logic                   neg_re, neg_im;
    logic                   sat_re, sat_im;
    logic                   dz;
    logic [CNT_W-1:0]       bit_cnt;

    function automatic logic signed [PW-1:0] sext(input logic signed [DATA_WIDTH-1:0] v);
        return {{(PW-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
    endfunction

    // ------------------------------------------------------------------
    // Full-precision products and numerator / denominator formation.
    // ------------------------------------------------------------------
    logic signed [PW-1:0] p_rr, p_ii, p_ir, p_ri, p_bb_re, p_bb_im;
    logic [NW-1:0]        nr, ni, d_sum, nr_mag, ni_mag;
    logic [CW-1:0]        scaled_re, scaled_im, den_lim;

    // NOTE: every signal written in an always_comb gets a default first so
    // that no path leaves it unassigned and no latch is inferred.
    always_comb begin
        p_rr    = sext(a_re) * sext(b_re);
        p_ii    = sext(a_im) * sext(b_im);
        p_ir    = sext(a_im) * sext(b_re);
        p_ri    = sext(a_re) * sext(b_im);
        p_bb_re = sext(b_re) * sext(b_re);
        p_bb_im = sext(b_im) * sext(b_im);

        nr      = {p_rr[PW-1], p_rr} + {p_ii[PW-1], p_ii};
        ni      = {p_ir[PW-1], p_ir} - {p_ri[PW-1], p_ri};
        // Squares are non-negative, so zero extension is exact.
        d_sum   = {1'b0, p_bb_re} + {1'b0, p_bb_im};

        nr_mag  = nr[NW-1] ? (~nr + NW'(1)) : nr;
        ni_mag  = ni[NW-1] ? (~ni + NW'(1)) : ni;

        scaled_re = {{(CW-NW){1'b0}}, nr_mag} << FRAC_BITS;
        scaled_im = {{(CW-NW){1'b0}}, ni_mag} << FRAC_BITS;

        // Any magnitude at or above this would need more than OUT_WIDTH-1
        // quotient bits.
        den_lim   = den << (OUT_WIDTH - 1);
    end

    // ------------------------------------------------------------------
    // Restoring-division step: subtract the shifted divisor when it fits.
    // ------------------------------------------------------------------
    logic          fit_re, fit_im;
    logic [CW-1:0] trial_re, trial_im;

    always_comb begin
        fit_re   = (rem_re >= dshift);
        fit_im   = (rem_im >= dshift);
        trial_re = rem_re - dshift;
        trial_im = rem_im - dshift;
    end

    // ------------------------------------------------------------------
    // Final sign / saturation / divide-by-zero resolution.
    // ------------------------------------------------------------------
    logic [OUT_WIDTH-1:0] fin_re, fin_im, mag_re, mag_im;

    always_comb begin
        mag_re = {1'b0, quo_re};
        mag_im = {1'b0, quo_im};
        fin_re = '0;
        fin_im = '0;
        if (!dz) begin
            // Saturation is symmetric: negative results stop at -MAX_POS.
            if (sat_re) fin_re = neg_re ? -MAX_POS : MAX_POS;
            else        fin_re = neg_re ? -mag_re  : mag_re;
            if (sat_im) fin_im = neg_im ? -MAX_POS : MAX_POS;
            else        fin_im = neg_im ? -mag_im  : mag_im;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and datapath registers.
    // ------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: every register, datapath included, is cleared so that an
            // aborted operation leaves no residue visible after reset.
            state       <= S_IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            result_real <= '0;
            result_imag <= '0;
            ovf         <= 1'b0;
            div_zero    <= 1'b0;
            a_re        <= '0;
            a_im        <= '0;
            b_re        <= '0;
            b_im        <= '0;
            rem_re      <= '0;
            rem_im      <= '0;
            den         <= '0;
            dshift      <= '0;
            quo_re      <= '0;
            quo_im      <= '0;
            neg_re      <= 1'b0;
            neg_im      <= 1'b0;
            sat_re      <= 1'b0;
            sat_im      <= 1'b0;
            dz          <= 1'b0;
            bit_cnt     <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    // in_ready is high throughout IDLE.
                    if (in_valid) begin
                        a_re     <= dataa_real;
                        a_im     <= dataa_imag;
                        b_re     <= datab_real;
                        b_im     <= datab_imag;
                        in_ready <= 1'b0;
                        state    <= S_MULT;
                    end
                end

                S_MULT: begin
                    rem_re <= scaled_re;
                    rem_im <= scaled_im;
                    neg_re <= nr[NW-1];
                    neg_im <= ni[NW-1];
                    den    <= {{(CW-NW){1'b0}}, d_sum};
                    state  <= S_CHECK;
                end

                S_CHECK: begin
                    sat_re  <= (rem_re >= den_lim);
                    sat_im  <= (rem_im >= den_lim);
                    dz      <= (den == '0);
                    dshift  <= den << (OUT_WIDTH - 2);
                    bit_cnt <= CNT_W'(OUT_WIDTH - 2);
                    quo_re  <= '0;
                    quo_im  <= '0;
                    state   <= S_DIV;
                end

                S_DIV: begin
                    // Bits of a saturated or divide-by-zero component are
                    // produced but discarded in DONE.
                    if (fit_re) rem_re <= trial_re;
                    if (fit_im) rem_im <= trial_im;
                    quo_re <= {quo_re[OUT_WIDTH-3:0], fit_re};
                    quo_im <= {quo_im[OUT_WIDTH-3:0], fit_im};
                    dshift <= dshift >> 1;
                    if (bit_cnt == '0) begin
                        state <= S_DONE;
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end

                S_DONE: begin
                    result_real <= fin_re;
                    result_imag <= fin_im;
                    ovf         <= ~dz & (sat_re | sat_im);
                    div_zero    <= dz;
                    out_valid   <= 1'b1;
                    in_ready    <= 1'b1;
                    state       <= S_IDLE;
                end

                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmpl_div.sv
// -----------------------------------------------------------------------------
// tb_cmpl_div -- self-checking bench for cmpl_div
//
// A behavioural model computes each expected quotient with plain 64-bit
// arithmetic. A monitor samples the DUT on every falling edge, predicts
// acceptances, and compares out_valid timing, in_ready and every result field
// against the model. Directed cases also pin the model and the DUT outputs
// to hand-computed literals.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cmpl_div;

    localparam int DW = 18;
    localparam int OW = 18;
    localparam int FB = 14;
    localparam longint LIM = 64'sd1 <<< (OW - 1);
    localparam int LAT = OW + 3;   // falling edges from accept sample to out_valid sample

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] ar = '0, ai = '0, br = '0, bi = '0;
    logic                 out_valid;
    logic signed [OW-1:0] result_real, result_imag;
    logic                 ovf, div_zero;

    cmpl_div #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .FRAC_BITS(FB)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dataa_real  (ar),
        .dataa_imag  (ai),
        .datab_real  (br),
        .datab_imag  (bi),
        .out_valid   (out_valid),
        .result_real (result_real),
        .result_imag (result_imag),
        .ovf         (ovf),
        .div_zero    (div_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        longint re;
        longint im;
        bit     ovf;
        bit     dz;
    } res_t;

    typedef struct {
        res_t r;
        int   due;
    } pend_t;

    pend_t  pend[$];
    int     acc_cyc[$];
    bit     stream_mode = 1'b0;
    int     ncyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: q = trunc((N * 2^FB) / D), symmetric saturation.
    function automatic longint sat(input longint q, output bit o);
        o = 1'b0;
        if (q >= LIM)  begin o = 1'b1; return LIM - 1;    end
        if (q <= -LIM) begin o = 1'b1; return -(LIM - 1); end
        return q;
    endfunction

    function automatic res_t model(input longint a_r, input longint a_i,
                                   input longint b_r, input longint b_i);
        res_t   r;
        longint nr, ni, d;
        bit     o_r, o_i;
        nr = a_r * b_r + a_i * b_i;
        ni = a_i * b_r - a_r * b_i;
        d  = b_r * b_r + b_i * b_i;
        if (d == 0) begin
            r.re = 0; r.im = 0; r.ovf = 1'b0; r.dz = 1'b1;
        end else begin
            // SV signed division truncates toward zero.
            r.re  = sat((nr * (64'sd1 <<< FB)) / d, o_r);
            r.im  = sat((ni * (64'sd1 <<< FB)) / d, o_i);
            r.ovf = o_r | o_i;
            r.dz  = 1'b0;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Monitor / comparator, sampled on the falling edge.
    // ------------------------------------------------------------------
    bit    due;
    res_t  e;
    pend_t p;

    always @(negedge clock) begin
        ncyc++;
        if (reset) begin
            pend.delete();
        end else begin
            due = (pend.size() > 0) && (pend[0].due == ncyc);
            check("out_valid timing", out_valid, due);
            check("in_ready", in_ready, (pend.size() == 0) || due);
            if (due) begin
                e = pend[0].r;
                void'(pend.pop_front());
                check("result_real", result_real, e.re);
                check("result_imag", result_imag, e.im);
                check("ovf", ovf, e.ovf);
                check("div_zero", div_zero, e.dz);
            end
            if (in_valid && in_ready) begin
                p.r   = model(ar, ai, br, bi);
                p.due = ncyc + LAT;
                pend.push_back(p);
                if (stream_mode) acc_cyc.push_back(ncyc);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers.
    // ------------------------------------------------------------------
    task automatic send(input longint a_r, input longint a_i,
                        input longint b_r, input longint b_i);
        bit got;
        got = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b1;
        ar = DW'(a_r); ai = DW'(a_i); br = DW'(b_r); bi = DW'(b_i);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("accept timeout", 0, 1);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            if (pend.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("result timeout", 0, 1);
        #1;
    endtask

    task automatic directed(input string nm,
                            input longint a_r, input longint a_i,
                            input longint b_r, input longint b_i,
                            input longint er, input longint ei,
                            input bit eo, input bit ez);
        res_t m;
        m = model(a_r, a_i, b_r, b_i);
        check({nm, " model re"}, m.re, er);
        check({nm, " model im"}, m.im, ei);
        check({nm, " model ovf"}, m.ovf, eo);
        check({nm, " model dz"}, m.dz, ez);
        send(a_r, a_i, b_r, b_i);
        wait_idle();
        check({nm, " re"}, result_real, er);
        check({nm, " im"}, result_imag, ei);
        check({nm, " ovf"}, ovf, eo);
        check({nm, " div_zero"}, div_zero, ez);
    endtask

    function automatic longint rand_comp();
        logic signed [DW-1:0] t;
        case ($urandom_range(0, 6))
            0:       return 0;
            1:       return longint'($urandom_range(0, 20)) - 10;
            2:       return -(64'sd1 <<< (DW - 1));
            3:       return (64'sd1 <<< (DW - 1)) - 1;
            default: begin
                t = DW'($urandom);
                return t;
            end
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Stimulus.
    // ------------------------------------------------------------------
    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset result_real", result_real, 0);
        check("reset result_imag", result_imag, 0);
        check("reset ovf", ovf, 0);
        check("reset div_zero", div_zero, 0);

        directed("identity",    1, 0,   1, 0,  16384,      0, 1'b0, 1'b0);
        directed("rot j/j",     0, 1,   0, 1,  16384,      0, 1'b0, 1'b0);
        directed("rot 1/j",     1, 0,   0, 1,      0, -16384, 1'b0, 1'b0);
        directed("trunc",       3, 4,   1, 2,  36044,  -6553, 1'b0, 1'b0);
        directed("ovf pos",   100, 0,   1, 0, 131071,      0, 1'b1, 1'b0);
        directed("ovf neg",  -100, 0,   1, 0, -131071,     0, 1'b1, 1'b0);
        directed("div zero",    5, -7,  0, 0,      0,      0, 1'b0, 1'b1);
        directed("zero num",    0, 0,   7, -3,     0,      0, 1'b0, 1'b0);

        // in_valid held high with operands changing every cycle.
        stream_mode = 1'b1;
        for (int i = 0; i < 110; i++) begin
            @(posedge clock); #1;
            in_valid = 1'b1;
            ar = DW'(rand_comp()); ai = DW'(rand_comp());
            br = DW'(rand_comp()); bi = DW'(rand_comp());
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        stream_mode = 1'b0;
        wait_idle();
        check("stream accept count", acc_cyc.size(), 6);
        for (int i = 1; i < acc_cyc.size(); i++)
            check("stream spacing", acc_cyc[i] - acc_cyc[i-1], LAT);

        // Reset five cycles after an accept aborts the operation.
        send(1, 0, 1, 0);
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("abort in_ready", in_ready, 1);
        check("abort result_real", result_real, 0);
        check("abort result_imag", result_imag, 0);
        check("abort ovf", ovf, 0);
        check("abort div_zero", div_zero, 0);
        repeat (30) @(posedge clock);   // monitor flags any stray out_valid
        directed("post reset", 1, 0, 1, 0, 16384, 0, 1'b0, 1'b0);

        // Randomised back-to-back operations.
        for (int i = 0; i < 300; i++)
            send(rand_comp(), rand_comp(), rand_comp(), rand_comp());
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
